// File: rtl/ysyx_22040386_mdu_pkg.sv
// Shared constants, FSM encoding and helpers for the RV64M multiply/divide unit.
package ysyx_22040386_mdu_pkg;

  localparam logic [2:0] MDU_MUL    = 3'b000;
  localparam logic [2:0] MDU_MULH   = 3'b001;
  localparam logic [2:0] MDU_MULHSU = 3'b010;
  localparam logic [2:0] MDU_MULHU  = 3'b011;
  localparam logic [2:0] MDU_DIV    = 3'b100;
  localparam logic [2:0] MDU_DIVU   = 3'b101;
  localparam logic [2:0] MDU_REM    = 3'b110;
  localparam logic [2:0] MDU_REMU   = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_CALC,
    S_FIX,
    S_DONE
  } mdu_state_e;

  // Widest supported XLEN; callers truncate to their own XLEN.
  function automatic logic [63:0] sext32(input logic [31:0] x);
    return {{32{x[31]}}, x};
  endfunction

endpackage

// File: rtl/ysyx_22040386_div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the divisor.
module ysyx_22040386_div_step #(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] dvs_i,
  input  logic            bit_i,
  output logic [XLEN-1:0] rem_o,
  output logic            q_o
);

  logic [XLEN:0] sh;
  logic [XLEN:0] diff;

  assign sh   = {rem_i, bit_i};
  assign diff = sh - {1'b0, dvs_i};
  // rem_i < dvs_i keeps sh below 2*dvs_i, so the MSB of diff is exactly the borrow.
  assign q_o   = ~diff[XLEN];
  assign rem_o = q_o ? diff[XLEN-1:0] : sh[XLEN-1:0];

endmodule

// File: rtl/ysyx_22040386_mdu.sv
// Multi-cycle RV64M multiply/divide unit: shift-add multiplier, restoring divider, valid/ready on both sides.
module ysyx_22040386_mdu
  import ysyx_22040386_mdu_pkg::*;
#(
  parameter int XLEN     = 64,
  parameter int MUL_BITS = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic            word_op,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  localparam int CW = 7;
  localparam int PW = 2 * XLEN;

  mdu_state_e      state_q, state_d;
  logic [2:0]      f3_q, f3_d;
  logic            wop_q, wop_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d;
  logic [PW-1:0]   acc_q, acc_d, mcand_q, mcand_d;
  logic [XLEN-1:0] mplier_q, mplier_d;
  logic [XLEN-1:0] rem_q, rem_d, quot_q, quot_d, dvs_q, dvs_d;
  logic            neg_q, neg_d, rneg_q, rneg_d, byp_q, byp_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] result_q, result_d;

  // Operand decode, evaluated from the latched request while in PREP.
  logic            is_div, s1_signed, s2_signed, a_neg, b_neg, div_zero, div_ovf;
  logic [31:0]     a_n32, b_n32;
  logic [XLEN-1:0] a_abs, b_abs, a_w;

  assign is_div    = f3_q[2];
  assign s1_signed = (f3_q == MDU_MULH) || (f3_q == MDU_MULHSU) ||
                     (f3_q == MDU_DIV)  || (f3_q == MDU_REM);
  assign s2_signed = (f3_q == MDU_MULH) || (f3_q == MDU_DIV) || (f3_q == MDU_REM);
  assign a_neg     = s1_signed & (wop_q ? a_q[31] : a_q[XLEN-1]);
  assign b_neg     = s2_signed & (wop_q ? b_q[31] : b_q[XLEN-1]);
  assign a_n32     = -a_q[31:0];
  assign b_n32     = -b_q[31:0];
  assign a_abs     = wop_q ? XLEN'(a_neg ? a_n32 : a_q[31:0]) : (a_neg ? -a_q : a_q);
  assign b_abs     = wop_q ? XLEN'(b_neg ? b_n32 : b_q[31:0]) : (b_neg ? -b_q : b_q);
  assign a_w       = wop_q ? XLEN'(sext32(a_q[31:0])) : a_q;
  assign div_zero  = wop_q ? (b_q[31:0] == 32'h0) : (b_q == '0);
  assign div_ovf   = is_div & s1_signed &
                     (wop_q ? (a_q[31:0] == 32'h8000_0000 && b_q[31:0] == 32'hFFFF_FFFF)
                            : (a_q == {1'b1, {(XLEN-1){1'b0}}} && b_q == '1));

  // Multiplier step: MUL_BITS shifted copies of the multiplicand per cycle.
  logic [PW-1:0] pp;
  always_comb begin
    pp = '0;
    for (int j = 0; j < MUL_BITS; j++)
      if (mplier_q[j]) pp = pp + (mcand_q << j);
  end

  logic [XLEN-1:0] step_rem;
  logic            step_q;

  ysyx_22040386_div_step #(.XLEN(XLEN)) u_div_step (
    .rem_i (rem_q),
    .dvs_i (dvs_q),
    .bit_i (quot_q[XLEN-1]),
    .rem_o (step_rem),
    .q_o   (step_q)
  );

  // Sign fix-up and field select.
  logic [PW-1:0]   prod;
  logic [XLEN-1:0] q_s, r_s, sel, fix_res;

  always_comb begin
    prod = neg_q ? -acc_q : acc_q;
    q_s  = neg_q ? -quot_q : quot_q;
    r_s  = rneg_q ? -rem_q : rem_q;
    if (byp_q)       sel = quot_q;
    else if (is_div) sel = f3_q[1] ? r_s : q_s;
    else             sel = (f3_q == MDU_MUL) ? prod[XLEN-1:0] : prod[PW-1:XLEN];
    fix_res = wop_q ? XLEN'(sext32(sel[31:0])) : sel;
  end

  always_comb begin
    state_d  = state_q;
    f3_d     = f3_q;
    wop_d    = wop_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    rem_d    = rem_q;
    quot_d   = quot_q;
    dvs_d    = dvs_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    byp_d    = byp_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = S_PREP;
          // Word-sized high multiplies collapse to MULW.
          f3_d  = (word_op && (funct3 == MDU_MULH || funct3 == MDU_MULHSU ||
                               funct3 == MDU_MULHU)) ? MDU_MUL : funct3;
          wop_d = word_op;
          a_d   = src1;
          b_d   = src2;
        end
      end
      S_PREP: begin
        neg_d  = a_neg ^ b_neg;
        rneg_d = a_neg;
        byp_d  = 1'b0;
        acc_d  = '0;
        if (is_div && (div_zero || div_ovf)) begin
          // Preloaded result rides through FIX so every op leaves via the same register.
          byp_d   = 1'b1;
          quot_d  = f3_q[1] ? (div_zero ? a_w : '0) : (div_zero ? '1 : a_w);
          state_d = S_FIX;
        end else if (is_div) begin
          rem_d   = '0;
          dvs_d   = b_abs;
          quot_d  = wop_q ? (a_abs << (XLEN - 32)) : a_abs;
          cnt_d   = wop_q ? CW'(32) : CW'(XLEN);
          state_d = S_CALC;
        end else begin
          mcand_d  = PW'(a_abs);
          mplier_d = b_abs;
          cnt_d    = wop_q ? CW'(32 / MUL_BITS) : CW'(XLEN / MUL_BITS);
          state_d  = S_CALC;
        end
      end
      S_CALC: begin
        cnt_d = cnt_q - CW'(1);
        if (is_div) begin
          rem_d  = step_rem;
          quot_d = {quot_q[XLEN-2:0], step_q};
        end else begin
          acc_d    = acc_q + pp;
          mcand_d  = mcand_q << MUL_BITS;
          mplier_d = mplier_q >> MUL_BITS;
        end
        if (cnt_q == CW'(1)) state_d = S_FIX;
      end
      S_FIX: begin
        result_d = fix_res;
        state_d  = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      f3_q     <= '0;
      wop_q    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      rem_q    <= '0;
      quot_q   <= '0;
      dvs_q    <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      byp_q    <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      f3_q     <= f3_d;
      wop_q    <= wop_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      rem_q    <= rem_d;
      quot_q   <= quot_d;
      dvs_q    <= dvs_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      byp_q    <= byp_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;

endmodule

// File: tb/tb_ysyx_22040386_mdu.sv
// Randomized scoreboard bench for the multiply/divide unit against an arithmetic reference model.
module tb_ysyx_22040386_mdu;

  logic        clk, rst_n, flush, in_valid, in_ready, word_op, out_valid, out_ready;
  logic [2:0]  funct3;
  logic [63:0] src1, src2, result;

  ysyx_22040386_mdu #(.XLEN(64), .MUL_BITS(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .funct3    (funct3),
    .word_op   (word_op),
    .src1      (src1),
    .src2      (src2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  typedef struct {
    logic [63:0] res;
    int          lat;
    int          acc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   n_popped = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Reference model: RISC-V M semantics from plain integer arithmetic.
  function automatic logic [63:0] ref_res(input logic [2:0] f, input logic w,
                                          input logic [63:0] a, input logic [63:0] b);
    logic [127:0] ea, eb, p;
    logic [31:0]  ua, ub, r32;
    int           sa32, sb32, t32;
    longint       sa, sb, t64;
    if (w) begin
      ua = a[31:0]; ub = b[31:0];
      sa32 = ua;    sb32 = ub;
      r32 = '0;
      case (f)
        3'd4: if (ub == 0) r32 = '1;
              else if (ua == 32'h8000_0000 && ub == 32'hFFFF_FFFF) r32 = ua;
              else begin t32 = sa32 / sb32; r32 = t32; end
        3'd5: r32 = (ub == 0) ? 32'hFFFF_FFFF : ua / ub;
        3'd6: if (ub == 0) r32 = ua;
              else if (ua == 32'h8000_0000 && ub == 32'hFFFF_FFFF) r32 = '0;
              else begin t32 = sa32 % sb32; r32 = t32; end
        3'd7: r32 = (ub == 0) ? ua : ua % ub;
        default: r32 = ua * ub;
      endcase
      return {{32{r32[31]}}, r32};
    end
    sa = a; sb = b;
    ea = {64'h0, a}; eb = {64'h0, b};
    case (f)
      3'd0: return a * b;
      3'd1: begin ea = {{64{a[63]}}, a}; eb = {{64{b[63]}}, b}; p = ea * eb; return p[127:64]; end
      3'd2: begin ea = {{64{a[63]}}, a}; p = ea * eb; return p[127:64]; end
      3'd3: begin p = ea * eb; return p[127:64]; end
      3'd4: if (b == 0) return '1;
            else if (a == 64'h8000_0000_0000_0000 && b == '1) return a;
            else begin t64 = sa / sb; return t64; end
      3'd5: return (b == 0) ? '1 : a / b;
      3'd6: if (b == 0) return a;
            else if (a == 64'h8000_0000_0000_0000 && b == '1) return '0;
            else begin t64 = sa % sb; return t64; end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] f, input logic w,
                                 input logic [63:0] a, input logic [63:0] b);
    logic zero, ovf;
    if (!f[2]) return w ? 32 / 2 + 2 : 64 / 2 + 2;
    zero = w ? (b[31:0] == 0) : (b == 0);
    ovf  = (f == 3'd4 || f == 3'd6) &&
           (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
              : (a == 64'h8000_0000_0000_0000 && b == '1));
    if (zero || ovf) return 2;
    return w ? 34 : 66;
  endfunction

  function automatic logic [63:0] rnd_op();
    case ($urandom_range(0, 7))
      0: return 64'h0;
      1: return '1;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'h0000_0000_8000_0000;
      4: return 64'($urandom_range(0, 20));
      5: return -64'($urandom_range(1, 20));
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  task automatic issue(input logic [2:0] f, input logic w, input logic [63:0] a, input logic [63:0] b);
    int   g;
    exp_t e;
    g = 0;
    @(negedge clk);
    while (!in_ready && g < 1000) begin @(negedge clk); g++; end
    if (!in_ready) begin
      total_cnt++;
      $display("FAIL issue_wait: in_ready got 0 expected 1 within 1000 cycles");
      return;
    end
    funct3 = f; word_op = w; src1 = a; src2 = b; in_valid = 1'b1;
    @(posedge clk); #1;
    e.res = ref_res(f, w, a, b);
    e.lat = exp_lat(f, w, a, b);
    e.acc = cyc;
    exp_q.push_back(e);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((exp_q.size() != 0 || !in_ready) && g < 3000) begin @(negedge clk); g++; end
    if (g >= 3000) begin
      total_cnt++;
      $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
    end
  endtask

  // Monitor: pops the scoreboard whenever a result is presented.
  initial begin
    exp_t        e;
    logic [63:0] r0;
    int          hold;
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid) begin
        if (exp_q.size() == 0) begin
          total_cnt++;
          $display("FAIL unexpected_out: out_valid got 1 expected 0 (result %h)", result);
          out_ready = 1'b1;
          @(negedge clk);
          out_ready = 1'b0;
        end else begin
          e = exp_q.pop_front();
          chk("result", result, e.res);
          chk("latency", 64'(cyc - e.acc), 64'(e.lat));
          r0   = result;
          hold = (n_popped == 0) ? 5 : $urandom_range(0, 3);
          n_popped++;
          repeat (hold) begin
            @(negedge clk);
            chk("hold_state", {61'h0, out_valid, in_ready, result == r0}, 64'b101);
          end
          out_ready = 1'b1;
          @(negedge clk);
          out_ready = 1'b0;
        end
      end else if (exp_q.size() != 0 && (cyc - exp_q[0].acc) > 300) begin
        total_cnt++;
        $display("FAIL timeout: no out_valid %0d cycles after accept, expected %0d",
                 cyc - exp_q[0].acc, exp_q[0].lat);
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [2:0] f;
    logic       w;
    int         ov_seen;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0;
    funct3 = '0; word_op = 1'b0; src1 = '0; src2 = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", {63'h0, in_ready}, 64'h1);
    chk("rst_out_valid", {63'h0, out_valid}, 64'h0);
    chk("rst_result", result, 64'h0);
    rst_n = 1'b1;

    issue(3'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF);
    issue(3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF);
    issue(3'd4, 1'b0, -64'd7, 64'd2);
    issue(3'd6, 1'b0, -64'd7, 64'd2);
    issue(3'd5, 1'b0, 64'h1234, 64'h0);
    issue(3'd7, 1'b0, 64'h1234, 64'h0);
    issue(3'd4, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF);
    issue(3'd6, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF);
    issue(3'd0, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'hFEDC_BA98_7654_3210);
    issue(3'd2, 1'b0, -64'd3, 64'hFFFF_FFFF_FFFF_FFFF);
    issue(3'd4, 1'b0, 64'h8000_0000_0000_0000, '1);
    issue(3'd5, 1'b1, 64'hFFFF_FFFF, 64'h1);

    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom_range(0, 7));
      w = 1'($urandom_range(0, 1));
      issue(f, w, rnd_op(), rnd_op());
    end
    drain();

    // Flush while the divider is iterating.
    issue(3'd4, 1'b0, 64'd1000, 64'd7);
    void'(exp_q.pop_back());
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_in_ready", {63'h0, in_ready}, 64'h1);
    ov_seen = 0;
    repeat (80) begin @(negedge clk); if (out_valid) ov_seen++; end
    chk("flush_no_out", 64'(ov_seen), 64'h0);

    // Flush coinciding with a request: nothing may be accepted.
    @(negedge clk);
    funct3 = 3'd0; word_op = 1'b0; src1 = 64'd5; src2 = 64'd6;
    in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_vs_valid", {63'h0, in_ready}, 64'h1);
    ov_seen = 0;
    repeat (50) begin @(negedge clk); if (out_valid) ov_seen++; end
    chk("flush_vs_valid_no_out", 64'(ov_seen), 64'h0);

    // Asynchronous reset in the middle of a multiply.
    issue(3'd0, 1'b0, 64'd3, 64'd5);
    void'(exp_q.pop_back());
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", {63'h0, in_ready}, 64'h1);
    chk("midrst_out_valid", {63'h0, out_valid}, 64'h0);
    chk("midrst_result", result, 64'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    issue(3'd6, 1'b0, 64'd100, -64'd7);
    issue(3'd1, 1'b1, 64'hFFFF_FFFF, 64'h2);
    drain();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
